// File: rtl/addr_bus_arbiter_if.sv
// Address-bus arbitration signals shared by the four address registers and the arbiter.
// master = requester/register side, slave = arbiter side.
interface addr_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] post_inc;
  logic [3:0] post_dec;
  logic       hold;
  logic [3:0] a_addr_n;
  logic [3:0] inc;
  logic [3:0] dec;
  logic [3:0] gnt;
  logic       busy;

  modport master (
    output req, post_inc, post_dec, hold,
    input  a_addr_n, inc, dec, gnt, busy
  );

  modport slave (
    input  req, post_inc, post_dec, hold,
    output a_addr_n, inc, dec, gnt, busy
  );
endinterface

// File: rtl/addr_bus_arbiter.sv
// Round-robin arbiter granting the address bus to PC/SP/SI/DI, with an optional
// one-cycle post-increment/decrement strobe after the address phase.
module addr_bus_arbiter (
  input  logic               clock,
  input  logic               clear_n,
  addr_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] idx;
  logic       lat_inc;
  logic       lat_dec;

  logic [3:0] a_addr_n_q;
  logic [3:0] inc_q;
  logic [3:0] dec_q;
  logic [3:0] gnt_q;
  logic       busy_q;

  logic [1:0] sel;
  logic [1:0] cand;
  logic       found;

  function automatic logic [3:0] one_hot(input logic [1:0] i);
    one_hot = 4'b0001 << i;
  endfunction

  // First requester at or above rr_ptr, wrapping 3 -> 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel   = rr_ptr;
    cand  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Outputs are loaded together with the state they belong to, so they are
  // registered yet already valid during the first cycle of that state.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state      <= IDLE;
      rr_ptr     <= 2'd0;
      idx        <= 2'd0;
      lat_inc    <= 1'b0;
      lat_dec    <= 1'b0;
      a_addr_n_q <= 4'b1111;
      inc_q      <= 4'b1111;
      dec_q      <= 4'b1111;
      gnt_q      <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx        <= sel;
            lat_inc    <= bus.post_inc[sel];
            lat_dec    <= bus.post_dec[sel];
            rr_ptr     <= sel + 2'd1;
            a_addr_n_q <= ~one_hot(sel);
            gnt_q      <= one_hot(sel);
            busy_q     <= 1'b1;
            state      <= ADDR;
          end
        end

        ADDR: begin
          if (!bus.hold) begin
            a_addr_n_q <= 4'b1111;
            if (lat_inc ^ lat_dec) begin
              inc_q <= ~({4{lat_inc}} & one_hot(idx));
              dec_q <= ~({4{lat_dec}} & one_hot(idx));
              state <= UPDATE;
            end else begin
              // Conflicting or absent flags: release without any strobe.
              gnt_q  <= 4'b0000;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end

        UPDATE: begin
          // Returning the strobe high here is the edge the register acts on.
          inc_q  <= 4'b1111;
          dec_q  <= 4'b1111;
          gnt_q  <= 4'b0000;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          a_addr_n_q <= 4'b1111;
          inc_q      <= 4'b1111;
          dec_q      <= 4'b1111;
          gnt_q      <= 4'b0000;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_addr_n = a_addr_n_q;
  assign bus.inc      = inc_q;
  assign bus.dec      = dec_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Randomized and directed bench for addr_bus_arbiter, checked every cycle against
// an access-level reference model of the arbitration rules.
module tb_addr_bus_arbiter;

  logic clock;
  logic clear_n;

  addr_bus_arbiter_if bus ();

  addr_bus_arbiter dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;

  // Reference model: the access in progress and who gets searched first next time.
  int m_phase;      // 0 no access, 1 address phase, 2 strobe cycle
  int m_owner;
  int m_first;
  bit m_inc;
  bit m_dec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit granted;
    if (!clear_n) begin
      m_phase = 0;
      m_first = 0;
    end else if (m_phase == 0) begin
      granted = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_first + k) % 4;
        if (!granted && bus.req[c]) begin
          granted = 1'b1;
          m_owner = c;
          m_inc   = bus.post_inc[c];
          m_dec   = bus.post_dec[c];
          m_first = (c + 1) % 4;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (!bus.hold) m_phase = (m_inc != m_dec) ? 2 : 0;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] oh;
    logic [3:0] e_addr, e_inc, e_dec, e_gnt;
    oh     = 4'b0001 << m_owner;
    e_addr = (m_phase == 1) ? ~oh : 4'b1111;
    e_inc  = (m_phase == 2 && m_inc) ? ~oh : 4'b1111;
    e_dec  = (m_phase == 2 && m_dec) ? ~oh : 4'b1111;
    e_gnt  = (m_phase != 0) ? oh : 4'b0000;
    check("a_addr_n", 32'(bus.a_addr_n), 32'(e_addr));
    check("inc",      32'(bus.inc),      32'(e_inc));
    check("dec",      32'(bus.dec),      32'(e_dec));
    check("gnt",      32'(bus.gnt),      32'(e_gnt));
    check("busy",     32'(bus.busy),     32'(m_phase != 0));
    check("inv_one_addr",   32'($countones(~bus.a_addr_n) <= 1), 32'd1);
    check("inv_one_strobe", 32'($countones(~{bus.inc, bus.dec}) <= 1), 32'd1);
    check("inv_no_overlap", 32'(!((~bus.a_addr_n != 4'b0) && (~{bus.inc, bus.dec} != 8'b0))), 32'd1);
    check("inv_gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] pi, input logic [3:0] pd, input logic h);
    bus.req      = r;
    bus.post_inc = pi;
    bus.post_dec = pd;
    bus.hold     = h;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    set_in(4'b0, 4'b0, 4'b0, 1'b0);
    tick();
    tick();
    clear_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_exp [9];
    vectors     = 0;
    miscompares = 0;
    m_phase     = 0;
    m_owner     = 0;
    m_first     = 0;
    m_inc       = 1'b0;
    m_dec       = 1'b0;
    clear_n     = 1'b0;
    set_in(4'b0, 4'b0, 4'b0, 1'b0);

    // Reset state
    do_reset();
    check("rst_addr", 32'(bus.a_addr_n), 32'hF);
    check("rst_gnt",  32'(bus.gnt),      32'h0);
    check("rst_busy", 32'(bus.busy),     32'h0);

    // Single request on PC with post-increment
    set_in(4'b0001, 4'b0001, 4'b0000, 1'b0);
    tick();
    check("s1_addr", 32'(bus.a_addr_n), 32'hE);
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("s1_inc",  32'(bus.inc),  32'hE);
    check("s1_busy", 32'(bus.busy), 32'h1);
    tick();
    check("s1_idle_inc",  32'(bus.inc),  32'hF);
    check("s1_idle_busy", 32'(bus.busy), 32'h0);

    // Round-robin with all four requesting
    do_reset();
    rr_exp = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE};
    set_in(4'b1111, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_addr", 32'(bus.a_addr_n), 32'(rr_exp[i]));
    end

    // Hold stretches the address phase of SI, then post-decrement
    do_reset();
    set_in(4'b0100, 4'b0000, 4'b0100, 1'b1);
    tick();
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("hold_addr", 32'(bus.a_addr_n), 32'hB);
      tick();
    end
    check("hold_addr", 32'(bus.a_addr_n), 32'hB);
    bus.hold = 1'b0;
    tick();
    check("hold_dec",  32'(bus.dec),      32'hB);
    check("hold_rel",  32'(bus.a_addr_n), 32'hF);
    tick();

    // Conflicting flags on SP: no strobe
    do_reset();
    set_in(4'b0010, 4'b0010, 4'b0010, 1'b0);
    tick();
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    check("conf_inc",  32'(bus.inc),  32'hF);
    check("conf_dec",  32'(bus.dec),  32'hF);
    check("conf_busy", 32'(bus.busy), 32'h0);

    // Inputs changed mid-access: latched flags win
    set_in(4'b0001, 4'b0001, 4'b0000, 1'b0);
    tick();
    set_in(4'b0000, 4'b0000, 4'b0001, 1'b1);
    tick();
    bus.hold = 1'b0;
    tick();
    check("mid_inc", 32'(bus.inc), 32'hE);
    check("mid_dec", 32'(bus.dec), 32'hF);
    tick();

    // Reset during the address phase of SP
    do_reset();
    set_in(4'b0010, 4'b0000, 4'b0001, 1'b0);
    tick();
    check("rma_addr", 32'(bus.a_addr_n), 32'hD);
    clear_n = 1'b0;
    set_in(4'b1111, 4'b1111, 4'b0000, 1'b1);
    tick();
    check("rma_rel",  32'(bus.a_addr_n), 32'hF);
    check("rma_gnt",  32'(bus.gnt),      32'h0);
    clear_n = 1'b1;
    tick();
    check("rma_pc_first", 32'(bus.a_addr_n), 32'hE);

    // Random traffic, including occasional resets
    for (int i = 0; i < 10000; i++) begin
      clear_n = ($urandom_range(0, 63) != 0);
      set_in(4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
